// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation datapath:
// state layout, FSM encodings, round constants and diffusion rotation amounts.
package ascon_pack;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Per-row rotation pairs for the linear layer, row 0 = x0.
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_constant(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] w, input int n);
        return (w >> n) | (w << (64 - n));
    endfunction

endpackage

// File: rtl/diffusion.sv
// ASCON linear diffusion layer: each row XORs in two rotated copies of itself.
module diffusion
    import ascon_pack::*;
(
    input  type_state source,
    output type_state result
);

    logic [63:0] words_in  [5];
    logic [63:0] words_out [5];

    assign words_in[0] = source.x0;
    assign words_in[1] = source.x1;
    assign words_in[2] = source.x2;
    assign words_in[3] = source.x3;
    assign words_in[4] = source.x4;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_row
            assign words_out[gi] = words_in[gi]
                                 ^ ror64(words_in[gi], ROT_A[gi])
                                 ^ ror64(words_in[gi], ROT_B[gi]);
        end
    endgenerate

    assign result = '{x0: words_out[0], x1: words_out[1], x2: words_out[2],
                      x3: words_out[3], x4: words_out[4]};

endmodule

// File: rtl/substitution.sv
// ASCON 5-bit S-box applied to all 64 columns at once, in bit-sliced form.
module substitution
    import ascon_pack::*;
(
    input  type_state source,
    output type_state result
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;

    always_comb begin
        a0 = source.x0 ^ source.x4;
        a1 = source.x1;
        a2 = source.x2 ^ source.x1;
        a3 = source.x3;
        a4 = source.x4 ^ source.x3;

        // Chi-like nonlinear step: each row absorbs ~next & next-next.
        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        result.x0 = b0 ^ b4;
        result.x1 = b1 ^ b0;
        result.x2 = ~b2;
        result.x3 = b3 ^ b2;
        result.x4 = b4;
    end

endmodule

// File: rtl/permutation_iter.sv
// Iterative ASCON permutation: one round (constant, S-box, diffusion) per clock,
// starting at a requested round index and finishing after the last round.
module permutation_iter
    import ascon_pack::*;
#(
    parameter int NB_ROUNDS_MAX = 12
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [3:0] round_start_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS_MAX - 1);

    logic [1:0] fsm_reg;
    logic [3:0] counter_reg;
    type_state  state_reg;

    type_state  added;
    type_state  substituted;
    type_state  diffused;
    logic       start_ok;

    assign start_ok = start_i && (round_start_i <= LAST_ROUND);

    always_comb begin
        added = state_reg;
        added.x2[7:0] = state_reg.x2[7:0] ^ round_constant(counter_reg);
    end

    substitution u_substitution (
        .source (added),
        .result (substituted)
    );

    diffusion u_diffusion (
        .source (substituted),
        .result (diffused)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_reg     <= ST_IDLE;
            counter_reg <= '0;
            state_reg   <= '0;
        end else begin
            case (fsm_reg)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts a new start directly so runs can chain.
                    if (start_ok) begin
                        state_reg   <= state_i;
                        counter_reg <= round_start_i;
                        fsm_reg     <= ST_RUN;
                    end else begin
                        fsm_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    state_reg <= diffused;
                    if (counter_reg == LAST_ROUND) begin
                        fsm_reg <= ST_DONE;
                    end else begin
                        counter_reg <= counter_reg + 4'd1;
                    end
                end
                default: fsm_reg <= ST_IDLE;
            endcase
        end
    end

    assign state_o = state_reg;
    assign busy_o  = (fsm_reg == ST_RUN);
    assign done_o  = (fsm_reg == ST_DONE);

endmodule

// File: tb/tb_permutation_iter.sv
// Self-checking bench for permutation_iter against a table-driven ASCON model.
module tb_permutation_iter;
    import ascon_pack::*;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic [3:0] round_start_i = 4'd0;
    type_state  state_i = '0;
    type_state  state_o;
    logic       busy_o;
    logic       done_o;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};

    permutation_iter #(.NB_ROUNDS_MAX(12)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .round_start_i (round_start_i),
        .state_i       (state_i),
        .state_o       (state_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
        logic [127:0] d;
        d = {w, w} >> n;
        return d[63:0];
    endfunction

    // Reference: rounds r0..11, S-box by table lookup per column.
    function automatic type_state model_perm(input type_state s, input int r0);
        logic [63:0] x [5];
        logic [4:0]  v, sv;
        type_state   res;
        x[0] = s.x0; x[1] = s.x1; x[2] = s.x2; x[3] = s.x3; x[4] = s.x4;
        for (int r = r0; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ 8'(240 - 15 * r);
            for (int i = 0; i < 64; i++) begin
                v = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
                sv = SBOX[v];
                x[0][i] = sv[4]; x[1][i] = sv[3]; x[2][i] = sv[2];
                x[3][i] = sv[1]; x[4][i] = sv[0];
            end
            for (int j = 0; j < 5; j++)
                x[j] = x[j] ^ rotr(x[j], RA[j]) ^ rotr(x[j], RB[j]);
        end
        res.x0 = x[0]; res.x1 = x[1]; res.x2 = x[2]; res.x3 = x[3]; res.x4 = x[4];
        return res;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        s.x0 = {$urandom, $urandom}; s.x1 = {$urandom, $urandom};
        s.x2 = {$urandom, $urandom}; s.x3 = {$urandom, $urandom};
        s.x4 = {$urandom, $urandom};
        return s;
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic launch(input type_state s, input logic [3:0] r0);
        state_i       = s;
        round_start_i = r0;
        start_i       = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Called right after the start edge; returns at the sample where done_o is seen.
    task automatic await_done(input string tag, input int n, input type_state exp, input bit poke);
        int cyc = 1;
        int busy_cnt = 0;
        int done_cyc = -1;
        while (cyc <= 40) begin
            start_i = 1'b0;
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            if (busy_o) busy_cnt++;
            if (poke && cyc == 2) begin
                start_i       = 1'b1;
                round_start_i = 4'd0;
                state_i       = rand_state();
            end
            tick();
            cyc++;
        end
        check({tag, "_done_cycle"}, 320'(done_cyc), 320'(n + 1));
        check({tag, "_busy_cycles"}, 320'(busy_cnt), 320'(n));
        check({tag, "_result"}, state_o, exp);
    endtask

    initial begin
        type_state s, init_s, prev, exp;
        int r0;

        // Reset held with start asserted.
        reset_i = 1'b1; start_i = 1'b1; state_i = rand_state(); round_start_i = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_state", state_o, '0);
            check("reset_busy_done", {busy_o, done_o}, 2'b00);
        end
        reset_i = 1'b0; start_i = 1'b0;
        tick();

        // Single round from all-zero.
        launch('0, 4'd11);
        await_done("single", 1, model_perm('0, 11), 1'b0);
        check("single_x0", state_o.x0, 64'h000964B00000004B);
        check("single_x4", state_o.x4, 64'h0);
        tick();
        check("single_pulse_end", {busy_o, done_o}, 2'b00);

        // Full p12 on the ASCON-128 init state, with a mid-run start poke.
        init_s = '0;
        init_s.x0 = 64'h80400c0600000000;
        launch(init_s, 4'd0);
        await_done("p12_init", 12, model_perm(init_s, 0), 1'b1);
        tick();
        prev = state_o;
        tick();
        check("idle_hold", state_o, prev);

        // p6 timing.
        s = rand_state();
        launch(s, 4'd6);
        await_done("p6", 6, model_perm(s, 6), 1'b0);
        tick();

        // Invalid round index ignored in IDLE.
        prev = state_o;
        for (int k = 12; k < 16; k++) begin
            launch(rand_state(), 4'(k));
            check("invalid_flags", {busy_o, done_o}, 2'b00);
            check("invalid_state", state_o, prev);
        end

        // Reset after five rounds aborts the run.
        launch(rand_state(), 4'd0);
        for (int i = 0; i < 5; i++) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("abort_state", state_o, '0);
        check("abort_flags", {busy_o, done_o}, 2'b00);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_o || busy_o) check("abort_no_done", {busy_o, done_o}, 2'b00);
        end

        // Back-to-back: start held during DONE chains without an idle cycle.
        s = rand_state();
        launch(s, 4'd8);
        await_done("chain_a", 4, model_perm(s, 8), 1'b0);
        s = rand_state();
        launch(s, 4'd9);
        await_done("chain_b", 3, model_perm(s, 9), 1'b0);
        tick();

        // Randomized runs.
        for (int t = 0; t < 8; t++) begin
            s = rand_state();
            r0 = $urandom_range(11, 0);
            exp = model_perm(s, r0);
            launch(s, 4'(r0));
            await_done($sformatf("rand%0d_r%0d", t, r0), 12 - r0, exp, (12 - r0) >= 3);
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
